// File: rtl/lsu_axi_ctrl.sv
// Load/store sequencer: turns one EX-stage memory request at a time into an
// AXI-lite transaction and holds the pipeline until the bus has answered.
module lsu_axi_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_rd_en,
    input  logic              req_wr_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_strb,
    input  logic              req_except,
    input  logic              flush,
    output logic              stall_req,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bus_err,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic [STRB_W-1:0] w_strb,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              is_wr_q, is_wr_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic              accept, busy;

    assign accept = (req_rd_en | req_wr_en) & ~req_except & ~flush;
    assign busy   = (state_q == RD_ADDR) | (state_q == RD_DATA) |
                    (state_q == WR_REQ)  | (state_q == WR_RESP);

    // Address/data come straight from the latched copy so they are stable while valid.
    assign ar_addr = addr_q;
    assign aw_addr = addr_q;
    assign w_data  = wdata_q;
    assign w_strb  = strb_q;
    assign rdata   = rdata_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        rdata_d     = rdata_q;
        is_wr_d     = is_wr_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        drop_d      = drop_q;
        err_d       = err_q;
        ar_valid    = 1'b0;
        r_ready     = 1'b0;
        aw_valid    = 1'b0;
        w_valid     = 1'b0;
        b_ready     = 1'b0;
        rdata_valid = 1'b0;
        bus_err     = 1'b0;
        stall_req   = busy | ((state_q == IDLE) & accept);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    strb_d    = req_strb;
                    is_wr_d   = req_wr_en;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    drop_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = req_wr_en ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    rdata_d = r_data;
                    err_d   = (r_resp != 2'b00);
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // Each channel retires independently; both may complete in one cycle.
                aw_valid  = ~aw_done_q;
                w_valid   = ~w_done_q;
                aw_done_d = aw_done_q | aw_ready;
                w_done_d  = w_done_q | w_ready;
                if (aw_done_d & w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    err_d   = (b_resp != 2'b00);
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata_valid = ~is_wr_q & ~drop_q;
                bus_err     = err_q & ~drop_q;
                drop_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The bus cannot abort, so a flush only marks the result for discard.
        if (busy & flush) drop_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            is_wr_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            is_wr_q   <= is_wr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Scoreboard bench for lsu_axi_ctrl: driver pushes expectations, slave models
// answer the bus with chosen delays, a monitor pops and compares.
module tb_lsu_axi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_rd_en = 0, req_wr_en = 0, req_except = 0, flush = 0;
    logic [63:0] req_addr = 0, req_wdata = 0;
    logic [7:0]  req_strb = 0;
    logic        stall_req, rdata_valid, bus_err;
    logic [63:0] rdata;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [63:0] ar_addr, r_data;
    logic [1:0]  r_resp, b_resp;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [63:0] aw_addr, w_data;
    logic [7:0]  w_strb;

    always #5 clk = ~clk;

    lsu_axi_ctrl #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_except(req_except),
        .flush(flush), .stall_req(stall_req), .rdata(rdata),
        .rdata_valid(rdata_valid), .bus_err(bus_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    typedef struct packed {
        int ar_d; int r_d; int aw_d; int w_d; int b_d;
        logic [63:0] data; logic [1:0] resp;
    } slv_t;
    typedef struct packed { logic is_rd; logic rdv; logic [63:0] data; logic err; } done_t;
    typedef struct packed { logic [63:0] d; logic [7:0] s; } wexp_t;

    slv_t        sl_r[$], sl_w[$];
    logic [63:0] exp_ar[$], exp_aw[$];
    wexp_t       exp_w[$];
    done_t       exp_done[$];
    logic [63:0] last_rdata = 0;
    int          total = 0, bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Read slave: ar_ready after ar_d cycles of ar_valid, r_valid r_d cycles later.
    initial begin : rd_slave
        int ph, cnt;
        slv_t s;
        ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0; ph = 0; cnt = 0; s = '0;
        forever begin
            @(posedge clk); #2;
            if (!rst_n) begin ph = 0; ar_ready = 0; r_valid = 0; continue; end
            if (ph == 3) begin r_valid = 0; ph = 0; end
            if (ph == 2) begin
                ar_ready = 0;
                if (cnt == 0) begin r_valid = 1; r_data = s.data; r_resp = s.resp; ph = 3; end
                else cnt--;
            end
            if (ph == 1) begin
                if (cnt == 0) begin ar_ready = 1; ph = 2; cnt = s.r_d; end else cnt--;
            end
            if (ph == 0 && ar_valid) begin
                s = (sl_r.size() != 0) ? sl_r.pop_front() : '0;
                if (s.ar_d == 0) begin ar_ready = 1; ph = 2; cnt = s.r_d; end
                else begin cnt = s.ar_d - 1; ph = 1; end
            end
        end
    end

    // Write slave: aw and w answered independently, b after both have completed.
    initial begin : wr_slave
        int ph, ac, wc, bc;
        logic ap, wp;
        slv_t s;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
        ph = 0; ac = 0; wc = 0; bc = 0; ap = 0; wp = 0; s = '0;
        forever begin
            @(posedge clk); #2;
            if (!rst_n) begin ph = 0; aw_ready = 0; w_ready = 0; b_valid = 0; continue; end
            if (ph == 2) begin b_valid = 0; ph = 0; end
            if (ph == 0 && (aw_valid || w_valid)) begin
                s = (sl_w.size() != 0) ? sl_w.pop_front() : '0;
                ap = 1; wp = 1; ac = s.aw_d; wc = s.w_d; bc = s.b_d; ph = 1;
            end
            if (ph == 1) begin
                if (aw_ready) begin aw_ready = 0; ap = 0; end
                else if (ap) begin if (ac == 0) aw_ready = 1; else ac--; end
                if (w_ready) begin w_ready = 0; wp = 0; end
                else if (wp) begin if (wc == 0) w_ready = 1; else wc--; end
                if (!ap && !wp) begin
                    if (bc == 0) begin b_valid = 1; b_resp = s.resp; ph = 2; end else bc--;
                end
            end
        end
    end

    // Monitor: bus channel contents against queues, completion pulses at DONE.
    initial begin : mon
        logic  ps;
        done_t e;
        ps = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin ps = 0; last_rdata = 0; continue; end
            if (ar_valid) begin
                if (exp_ar.size() == 0) chk("ar_valid_unexpected", ar_valid, 0);
                else begin
                    chk("ar_addr", ar_addr, exp_ar[0]);
                    if (ar_ready) void'(exp_ar.pop_front());
                end
            end
            if (aw_valid) begin
                if (exp_aw.size() == 0) chk("aw_valid_unexpected", aw_valid, 0);
                else begin
                    chk("aw_addr", aw_addr, exp_aw[0]);
                    if (aw_ready) void'(exp_aw.pop_front());
                end
            end
            if (w_valid) begin
                if (exp_w.size() == 0) chk("w_valid_unexpected", w_valid, 0);
                else begin
                    chk("w_data", w_data, exp_w[0].d);
                    chk("w_strb", w_strb, exp_w[0].s);
                    if (w_ready) void'(exp_w.pop_front());
                end
            end
            if (ps && !stall_req) begin
                if (exp_done.size() == 0) chk("done_unexpected", stall_req, 1);
                else begin
                    e = exp_done.pop_front();
                    if (e.is_rd) last_rdata = e.data;
                    chk("rdata_valid", rdata_valid, e.rdv);
                    chk("bus_err", bus_err, e.err);
                    chk("rdata", rdata, last_rdata);
                end
            end else if (rdata_valid || bus_err) begin
                chk("pulse_outside_done", {rdata_valid, bus_err}, 0);
            end
            ps = stall_req;
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_ar_valid"}, ar_valid, 0);
        chk({tag, "_aw_valid"}, aw_valid, 0);
        chk({tag, "_w_valid"}, w_valid, 0);
        chk({tag, "_r_ready"}, r_ready, 0);
        chk({tag, "_b_ready"}, b_ready, 0);
        chk({tag, "_stall"}, stall_req, 0);
        chk({tag, "_rdata_valid"}, rdata_valid, 0);
        chk({tag, "_bus_err"}, bus_err, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // One EX request; fl_at>0 pulses flush that many cycles after the issue cycle.
    task automatic txn(input logic rd, input logic wr, input logic exc, input logic fl0,
                       input int fl_at, input int hold, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [7:0] st, input slv_t s);
        logic  acc;
        int    n, c, exp_n;
        done_t e;
        acc = (rd | wr) & ~exc & ~fl0;
        exp_n = 0;
        if (acc) begin
            if (wr) begin
                exp_aw.push_back(addr);
                exp_w.push_back({wd, st});
                sl_w.push_back(s);
                exp_n = 3 + mx(s.aw_d, s.w_d) + s.b_d;
            end else begin
                exp_ar.push_back(addr);
                sl_r.push_back(s);
                exp_n = 3 + s.ar_d + s.r_d;
            end
            e.is_rd = ~wr;
            e.data  = s.data;
            e.rdv   = ~wr && (fl_at == 0);
            e.err   = (s.resp != 2'b00) && (fl_at == 0);
            exp_done.push_back(e);
        end
        @(posedge clk); #1;
        req_rd_en = rd; req_wr_en = wr; req_except = exc; flush = fl0;
        req_addr = addr; req_wdata = wd; req_strb = st;
        @(negedge clk);
        chk("stall_at_issue", stall_req, acc);
        if (acc) begin
            n = 1; c = 0;
            do begin
                @(posedge clk); #1;
                c++;
                flush = (fl_at != 0) && (c == fl_at);
                @(negedge clk);
                if (stall_req) n++;
            end while (stall_req && c < 200);
            flush = 0;
            chk("stall_released", stall_req, 0);
            chk("stall_cycles", n, exp_n);
        end else begin
            for (int j = 0; j < hold; j++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("stall_no_issue", stall_req, 0);
            end
        end
    endtask

    initial begin : main
        slv_t s;
        logic rd, wr, exc, fl0;
        int   k, fl_at;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1 rst_n = 1;

        // Zero-wait read: three stall cycles, data returned.
        s = '{0, 0, 0, 0, 0, 64'h1122334455667788, 2'b00};
        txn(1, 0, 0, 0, 0, 0, 64'h80000010, 0, 0, s);
        // Store: w accepted at once, aw four cycles in.
        s = '{0, 0, 3, 0, 0, 64'h0, 2'b00};
        txn(0, 1, 0, 0, 0, 0, 64'h80000020, 64'hdeadbeefcafef00d, 8'hFF, s);
        // Excepting load held five cycles: never issued.
        txn(1, 0, 1, 0, 0, 4, 64'h80000031, 0, 0, s);
        // Flush during RD_DATA, data three cycles later.
        s = '{0, 3, 0, 0, 0, 64'h0badf00d0badf00d, 2'b00};
        txn(1, 0, 0, 0, 2, 0, 64'h80000040, 0, 0, s);
        // Store with SLVERR.
        s = '{0, 0, 1, 2, 1, 64'h0, 2'b10};
        txn(0, 1, 0, 0, 0, 0, 64'h80000050, 64'h55, 8'h0F, s);
        // Both enables set: write wins.
        s = '{0, 0, 0, 0, 0, 64'h0, 2'b00};
        txn(1, 1, 0, 0, 0, 0, 64'h80000060, 64'h1234, 8'h03, s);

        // Reset while aw is still pending.
        s = '{0, 0, 20, 0, 0, 64'h0, 2'b00};
        exp_aw.push_back(64'h80000070);
        exp_w.push_back({64'h77, 8'hF0});
        sl_w.push_back(s);
        @(posedge clk); #1;
        req_rd_en = 0; req_wr_en = 1; req_addr = 64'h80000070; req_wdata = 64'h77; req_strb = 8'hF0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 0; req_wr_en = 0;
        @(posedge clk);
        @(negedge clk);
        chk_idle("midreset");
        exp_aw.delete(); exp_w.delete(); sl_w.delete(); exp_done.delete();
        @(posedge clk); #1 rst_n = 1;
        s = '{1, 1, 0, 0, 0, 64'hfeedface01020304, 2'b00};
        txn(1, 0, 0, 0, 0, 0, 64'h80000080, 0, 0, s);

        for (int i = 0; i < 150; i++) begin
            k   = int'($urandom_range(0, 9));
            rd  = (k < 4) || (k == 8);
            wr  = (k >= 4 && k < 8) || (k == 8);
            exc = ($urandom_range(0, 9) == 0);
            fl0 = ($urandom_range(0, 19) == 0);
            fl_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            s.ar_d = int'($urandom_range(0, 3));
            s.r_d  = int'($urandom_range(0, 3));
            s.aw_d = int'($urandom_range(0, 3));
            s.w_d  = int'($urandom_range(0, 3));
            s.b_d  = int'($urandom_range(0, 3));
            if (fl_at != 0) begin
                if (s.r_d < 3) s.r_d = 3;
                if (s.b_d < 3) s.b_d = 3;
            end
            s.data = {$urandom, $urandom};
            s.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            txn(rd, wr, exc, fl0, fl_at, int'($urandom_range(1, 3)),
                {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), s);
        end

        @(posedge clk); #1;
        req_rd_en = 0; req_wr_en = 0; req_except = 0; flush = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("exp_done_left", exp_done.size(), 0);
        chk("exp_ar_left", exp_ar.size(), 0);
        chk("exp_aw_left", exp_aw.size(), 0);
        chk("exp_w_left", exp_w.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
